mem_arbiter: RTL
================

# mem_arbiter

Shares the single-port 32x8 program/data memory between the stack CPU's instruction-fetch unit and its stack (push/pop) unit. Each cycle it picks at most one requester with round-robin arbitration, drives `adr`/`data`/`memwen`/`memRead`, and returns the memory's registered read data to the requester that issued the read. A bounded lock lets the stack unit perform back-to-back accesses, such as pop-then-write, without the fetch unit interleaving.

## Interface
- `ADR_W`, 5: memory address width.
- `DATA_W`, 8: memory data width.
- `MAX_LOCK`, 4: maximum consecutive locked grants to the data port before the lock is ignored for one arbitration.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `f_req` input 1: fetch request. Must be held, with stable `f_adr`, until `f_gnt`.
- `f_adr` input ADR_W: fetch address. Fetch is read-only.
- `f_gnt` output 1: fetch access issued this cycle.
- `f_rvalid` output 1: `f_rdata` valid this cycle.
- `f_rdata` output DATA_W: fetch read data. Zero when `f_rvalid` is 0.
- `d_req` input 1: data request. Must be held, with stable `d_we`/`d_adr`/`d_wdata`, until `d_gnt`.
- `d_we` input 1: 1 = write, 0 = read.
- `d_adr` input ADR_W: data address.
- `d_wdata` input DATA_W: write data.
- `d_lock` input 1: request to keep ownership after this grant.
- `d_gnt` output 1: data access issued this cycle.
- `d_rvalid` output 1: `d_rdata` valid this cycle.
- `d_rdata` output DATA_W: data read data. Zero when `d_rvalid` is 0.
- `adr` output ADR_W: to memory `adr`.
- `data` output DATA_W: to memory `data`.
- `memwen` output 1: to memory `memwen`.
- `memRead` output 1: to memory `memRead`.
- `resMem` input DATA_W: from memory. Registered, valid the cycle after `memRead`.

## Operation
- **Grant rule.** At most one of `f_gnt`/`d_gnt` is high per cycle. A grant is issued only when the corresponding `req` is high.
- **Round robin.** With both ports requesting and no active lock, the port not granted most recently wins. `last` is a 1-bit register, reset to DATA, so FETCH wins the first contention.
- **Fetch grant.** `adr=f_adr`, `memRead=1`, `memwen=0`.
- **Data grant, write.** `adr=d_adr`, `data=d_wdata`, `memwen=1`, `memRead=0`. No rvalid follows.
- **Data grant, read.** `adr=d_adr`, `memRead=1`.
- **Idle.** With no grant, `memwen=memRead=0`, `adr=0`, `data=0`.
- **Read tracking.** Registers `rd_pend` (1 bit) and `rd_tag` (FETCH/DATA) are set on any read grant. Next cycle the tagged port's `rvalid=1` and its `rdata=resMem`. The other port's `rdata` is 0.
- **Lock.**
  - A data grant with `d_lock=1` sets `locked` and increments `lock_cnt`.
  - While `locked`, fetch is not granted.
  - `locked` clears on: a data grant with `d_lock=0`; any cycle with `d_req=0`; or `lock_cnt` reaching `MAX_LOCK`.
  - When the limit is reached, the next arbitration ignores the lock and grants FETCH if `f_req` is high.
  - `lock_cnt` resets to 0 whenever `locked` clears.
- **Pipelining.** Back-to-back accesses are allowed: a new grant may occur in the same cycle as an `rvalid` from the previous read.
- **Write-then-read to the same address.** A read in the cycle after a write returns the new value (the memory commits the write at the grant-cycle edge).

## Timing
- `f_gnt`, `d_gnt`, `adr`, `data`, `memwen` and `memRead` are combinational from requests and registered state. Zero latency from `req` to grant when the port wins.
- Read latency is exactly 1 cycle: grant in cycle N, `rvalid` in cycle N+1.
- Reset values:
  - All outputs are 0 while `rst=1`.
  - `last`=DATA, `rd_pend`=0, `locked`=0, `lock_cnt`=0.
- Reset during a pending read: `rvalid` is suppressed. The read result is discarded and never delivered after reset.
- Simultaneous requests while locked: DATA is granted. FETCH keeps `f_req` held and sees no grant.
- Request deasserted before grant: protocol violation. Required behaviour is only that no grant goes to a port whose `req` is low.

## Structure
- Package `mem_arb_pkg` holds:
  - `ADR_W` and `DATA_W` defaults.
  - Port-id constants `PORT_F=1'b0`, `PORT_D=1'b1`.
  - `MAX_LOCK` default.
- Sub-module `arb_rr2` is a 2-way round-robin picker.
  - Inputs: two requests, `last`, `force_d`.
  - Output: one-hot grant.
- Lock counter, read tag and output muxing stay in `mem_arbiter`.

## Test plan
- **Reset priority:** after reset, `f_req=1` (`f_adr=3`) and `d_req=1` in the same cycle → `f_gnt=1`, `adr=3`, `memRead=1`. Next cycle `f_rvalid=1`, `f_rdata=resMem` (0xC7 with the program image).
- **Round robin:** both ports request continuously with reads → grants alternate F, D, F, D. Each `rvalid` follows its grant by 1 cycle with the correct tag.
- **Write/read:** `d_we=1`, `d_adr=31`, `d_wdata=0xBB`; next cycle a `d_we=0` read of 31 → `memwen` pulses 1 cycle, then `d_rvalid=1` with `d_rdata=0xBB`.
- **Lock limit:** `d_lock=1`, `d_req` held, `f_req` held → exactly 4 consecutive `d_gnt`, then `f_gnt`, then DATA again.
- **Lock release:** a data grant with `d_lock=0` while `f_req` is high → `f_gnt` in the next cycle.
- **Reset mid-read:** `rst=1` in the cycle after a fetch grant → `f_rvalid=0`, all outputs 0, and no `rvalid` appears after `rst` falls.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the program/data memory arbiter:
// default widths, lock limit and the port identifiers used as tags.
package mem_arb_pkg;

    localparam int DEF_ADR_W    = 5;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_MAX_LOCK = 4;

    // Port ids double as bit positions in the one-hot grant vector
    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: fetch vs. data, with a force that
// restricts the choice to the data port while it holds the lock.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       req_f,
    input  logic       req_d,
    input  logic       last,
    input  logic       force_d,
    output logic [1:0] gnt
);

    // One-hot pick; under contention the port not granted last time wins
    always_comb begin
        gnt = 2'b00;
        if (force_d) begin
            gnt[PORT_D] = req_d;
        end else begin
            case ({req_d, req_f})
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last == PORT_D) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port program/data memory between instruction
// fetch and the stack unit, with a bounded data-port lock and read-return routing.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADR_W    = DEF_ADR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADR_W-1:0]  f_adr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADR_W-1:0]  d_adr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADR_W-1:0]  adr,
    output logic [DATA_W-1:0] data,
    output logic              memwen,
    output logic              memRead,
    input  logic [DATA_W-1:0] resMem
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(MAX_LOCK);

    logic             last_r;
    logic             rd_pend_r;
    logic             rd_tag_r;
    logic             locked_r;
    logic [CNT_W-1:0] lock_cnt_r;

    logic [1:0]       gnt_s;
    logic             locked_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_inc_s;

    arb_rr2 u_rr (
        .req_f   (f_req),
        .req_d   (d_req),
        .last    (last_r),
        .force_d (locked_r),
        .gnt     (gnt_s)
    );

    // Grants are zero-latency but forced low during reset
    always_comb begin
        f_gnt = gnt_s[PORT_F] & ~rst;
        d_gnt = gnt_s[PORT_D] & ~rst;
    end

    // Lock bookkeeping: the count restarts whenever the lock drops
    always_comb begin
        locked_nxt_s = locked_r;
        cnt_nxt_s    = lock_cnt_r;
        cnt_inc_s    = lock_cnt_r + CNT_W'(1);
        if (!d_req) begin
            locked_nxt_s = 1'b0;
            cnt_nxt_s    = '0;
        end else if (d_gnt && d_lock) begin
            if (cnt_inc_s == LOCK_LIM) begin
                locked_nxt_s = 1'b0;
                cnt_nxt_s    = '0;
            end else begin
                locked_nxt_s = 1'b1;
                cnt_nxt_s    = cnt_inc_s;
            end
        end else if (d_gnt) begin
            locked_nxt_s = 1'b0;
            cnt_nxt_s    = '0;
        end else begin
            locked_nxt_s = locked_r;
            cnt_nxt_s    = lock_cnt_r;
        end
    end

    // Memory-side mux; idle drives everything to zero
    always_comb begin
        adr     = {ADR_W{1'b0}};
        data    = {DATA_W{1'b0}};
        memwen  = 1'b0;
        memRead = 1'b0;
        if (f_gnt) begin
            adr     = f_adr;
            memRead = 1'b1;
        end else if (d_gnt) begin
            adr = d_adr;
            if (d_we) begin
                data   = d_wdata;
                memwen = 1'b1;
            end else begin
                memRead = 1'b1;
            end
        end else begin
            adr     = {ADR_W{1'b0}};
            memRead = 1'b0;
        end
    end

    // Read return routed by tag; reset suppresses any in-flight result
    always_comb begin
        f_rvalid = rd_pend_r & (rd_tag_r == PORT_F) & ~rst;
        d_rvalid = rd_pend_r & (rd_tag_r == PORT_D) & ~rst;
        f_rdata  = f_rvalid ? resMem : {DATA_W{1'b0}};
        d_rdata  = d_rvalid ? resMem : {DATA_W{1'b0}};
    end

    // Arbitration history, read tracking and lock state
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r     <= PORT_D;
            rd_pend_r  <= 1'b0;
            rd_tag_r   <= PORT_F;
            locked_r   <= 1'b0;
            lock_cnt_r <= '0;
        end else begin
            if (f_gnt) begin
                last_r   <= PORT_F;
                rd_tag_r <= PORT_F;
            end else if (d_gnt) begin
                last_r   <= PORT_D;
                rd_tag_r <= PORT_D;
            end
            rd_pend_r  <= f_gnt | (d_gnt & ~d_we);
            locked_r   <= locked_nxt_s;
            lock_cnt_r <= cnt_nxt_s;
        end
    end

endmodule
